// File: rtl/pulpino_host_mailbox.sv
// Core-side host mailbox: APB slave passing 32-bit words between the
// CW305 register file and PULPino software, with status and handshake.
module pulpino_host_mailbox #(
    parameter int pADDR_W = 12,
    parameter int pCNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [pADDR_W-1:0] paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [31:0]        host_data_i,
    input  logic               host_strobe_i,
    output logic [31:0]        mbox_wdata_o,
    output logic [31:0]        mbox_ctrl_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               irq_o
);

    logic [31:0]       rx_data_q, rx_data_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic [31:0]       prdata_q, prdata_d;
    logic [pCNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [pCNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              tx_valid_q, tx_valid_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q;

    logic        addr_ok, err, setup, access, acc_ok;
    logic        wr_tx, wr_ctrl, rd_rx;
    logic [1:0]  sel;
    logic [31:0] status, rd_val;

    assign sel     = paddr[3:2];
    assign addr_ok = (paddr[pADDR_W-1:4] == '0) && (paddr[1:0] == 2'b00);
    // RX_DATA (00) and STATUS (10) are read-only
    assign err     = !addr_ok || (pwrite && !sel[0]);
    assign setup   = psel && !penable;
    assign access  = psel && penable;
    assign acc_ok  = access && !err;
    assign wr_tx   = acc_ok && pwrite && (sel == 2'd1);
    assign wr_ctrl = acc_ok && pwrite && (sel == 2'd3);
    assign rd_rx   = acc_ok && !pwrite && (sel == 2'd0);

    assign status = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 5'h00,
                     tx_valid_q, rx_ovr_q, rx_valid_q};

    always_comb begin
        rd_val = 32'h0;
        if (addr_ok) begin
            unique case (sel)
                2'd0: rd_val = rx_data_q;
                2'd1: rd_val = tx_data_q;
                2'd2: rd_val = status;
                2'd3: rd_val = {31'h0, irq_en_q};
            endcase
        end
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        tx_data_d  = tx_data_q;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        tx_valid_d = tx_valid_q;
        irq_en_d   = irq_en_q;
        prdata_d   = prdata_q;

        if (setup && !pwrite) begin
            prdata_d = rd_val;
        end

        if (wr_ctrl) begin
            irq_en_d = pwdata[0];
            if (pwdata[1]) rx_ovr_d = 1'b0;
            if (pwdata[2]) tx_valid_d = 1'b0;
        end

        // A strobe racing the clearing read keeps rx_valid and is no overrun
        if (host_strobe_i) begin
            rx_data_d  = host_data_i;
            rx_valid_d = 1'b1;
            rx_cnt_d   = rx_cnt_q + pCNT_W'(1);
            if (rx_valid_q && !rd_rx) rx_ovr_d = 1'b1;
        end else if (rd_rx) begin
            rx_valid_d = 1'b0;
        end

        if (wr_tx) begin
            tx_data_d  = pwdata;
            tx_valid_d = 1'b1;
            tx_cnt_d   = tx_cnt_q + pCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_q  <= 32'h0;
            tx_data_q  <= 32'h0;
            prdata_q   <= 32'h0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            tx_data_q  <= tx_data_d;
            prdata_q   <= prdata_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_valid_q <= tx_valid_d;
            irq_en_q   <= irq_en_d;
            done_q     <= wr_tx;
        end
    end

    assign prdata       = prdata_q;
    assign pready       = 1'b1;
    assign pslverr      = access && err;
    assign mbox_wdata_o = tx_data_q;
    assign mbox_ctrl_o  = status;
    assign busy_o       = rx_valid_q;
    assign done_o       = done_q;
    assign irq_o        = irq_en_q && rx_valid_q;

endmodule
